sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Single-clock, fully parametrised FIFO. It is the successor to the team's fixed 16x4 buffer, generalised in width and depth.
- Adds an occupancy count, programmable almost-full and almost-empty flags, a selectable first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags.
- Used wherever producer and consumer share one clock domain, for example as a staging buffer ahead of clock-domain-crossing FIFOs.

Parameters:
- DATA_WIDTH, 4: width of each stored word.
- DEPTH, 16: number of entries. Must be a power of 2 and at least 2.
- ADDR_WIDTH, $clog2(DEPTH): pointer index width. Derived; do not override.
- AFULL_THRESH, DEPTH-2: almost_full asserts when count >= AFULL_THRESH.
- AEMPTY_THRESH, 2: almost_empty asserts when count <= AEMPTY_THRESH.
- FWFT, 0: read mode. 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk, input, 1: single clock. All logic is on the rising edge.
- reset, input, 1: synchronous reset, active-high.
- data_in, input, DATA_WIDTH: write data.
- wr_en, input, 1: write request.
- rd_en, input, 1: read request (pop).
- data_out, output, DATA_WIDTH: read data.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- almost_full, output, 1: count >= AFULL_THRESH.
- almost_empty, output, 1: count <= AEMPTY_THRESH.
- count, output, ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky. Set by a write attempted while full.
- underflow, output, 1: sticky. Set by a read attempted while empty.

Behaviour:
- Reset (synchronous, active-high):
  - wr_ptr, rd_ptr and count go to 0. data_out goes to 0. overflow and underflow go to 0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0 (almost_full=0 given AFULL_THRESH >= 1).
  - Memory contents are not reset.
  - Reset overrides any same-cycle wr_en or rd_en. Reset mid-stream discards all stored data.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide. The MSB is the wrap bit; the low ADDR_WIDTH bits index memory.
  - Each pointer increments modulo 2^(ADDR_WIDTH+1) on an accepted access.
- Acceptance:
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
  - Both are decided from the flags as they stand in the current cycle.
- Occupancy:
  - count <= count + wr_acc - rd_acc.
  - A simultaneous accepted read and write leaves count unchanged; both pointers advance.
- Full/empty edge cases:
  - Full with wr_en=1 and rd_en=1: the read is accepted and the write is rejected. overflow is set and count becomes DEPTH-1.
  - Empty with wr_en=1 and rd_en=1: the write is accepted and the read is rejected. underflow is set and count becomes 1.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of the registered count. They therefore update the cycle after the access that changes count.
- Error flags:
  - overflow <= overflow | (wr_en & full).
  - underflow <= underflow | (rd_en & empty).
  - Only reset clears them.
- Standard read mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]], visible one cycle after rd_en.
  - With no accepted read, data_out holds its value.
- FWFT read mode (FWFT=1):
  - data_out = mem[rd_ptr index] combinationally, so the head word is valid whenever empty=0.
  - rd_acc pops the head; the next word appears in the same cycle the pointer updates.
  - While empty, data_out is don't-care. The bench masks it.
- Memory write: on wr_acc, mem[wr_ptr index] <= data_in.
- Read-during-write: memory is written at the clock edge.
  - FWFT mode: a word written into an empty FIFO is visible on data_out the cycle after the write.
  - Standard mode: the earliest read of that word is rd_en asserted in the cycle after the write.
- Wrap-around: after 2*DEPTH accepted writes and reads, both pointers return to 0. Full is never confused with empty, because count is the sole source of the flags.

Decomposition:
- Shared package fifo_pkg:
  - localparam FWFT_OFF=0, FWFT_ON=1.
  - A clog2-based helper for pointer width.
  - Nothing block-specific beyond these.
- Sub-module fifo_ram:
  - DATA_WIDTH x DEPTH register array with a write port (we, waddr, wdata) and a combinational read port (raddr, rdata).
  - The top level adds the output register in standard mode.
  - fifo_ram is intended for reuse by the asynchronous FIFO.

Test Plan:
- Reset, then write 0x1..0xF and 0x0 with DEPTH=16, DATA_WIDTH=4 -> count climbs 1..16. almost_full first asserts at count=14. full=1 at 16 with no overflow. A 17th write sets overflow=1 and memory is unchanged.
- Read all 16 in standard mode -> data_out 0x1..0xF, 0x0 in order, each one cycle after its rd_en. empty=1 after the last read. An extra rd_en sets underflow=1 and data_out holds 0x0.
- Simultaneous wr_en/rd_en:
  - Hold both high for 40 cycles with count=5 -> count stays 5, output order is preserved, and both pointers wrap past 31 to 0.
  - At full -> count becomes 15 and overflow is set.
  - At empty -> count becomes 1 and underflow is set.
- FWFT=1: write 0xA into an empty FIFO -> next cycle empty=0 and data_out=0xA with no rd_en. Write 0xB, then pulse rd_en -> data_out=0xB in the following cycle.
- Assert reset mid-stream with count=9, overflow=1 and wr_en=1 -> next cycle count=0, empty=1, overflow=0 and data_out=0; the same-cycle write is dropped.
- Parameter sweep DATA_WIDTH=8, DEPTH=64, AFULL_THRESH=60, AEMPTY_THRESH=4 -> almost_empty deasserts at count=5, almost_full asserts at count=60, full at 64, and random push/pop data integrity matches a scoreboard.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode selectors and pointer sizing.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // One extra bit beyond the memory index serves as the wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Register-array storage with one write port and a combinational read port,
// shared by the synchronous and asynchronous FIFOs.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset so the array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost
// flags, optional first-word-fall-through output and sticky error flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 4,
  parameter int DEPTH         = 16,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = FWFT_OFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W-1:0] FULL_CNT   = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AFULL_CNT  = PTR_W'(AFULL_THRESH);
  localparam logic [PTR_W-1:0] AEMPTY_CNT = PTR_W'(AEMPTY_THRESH);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Flags come only from count, so a wrapped full FIFO never looks empty.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_acc && !rd_acc)      count <= count + PTR_ONE;
      else if (rd_acc && !wr_acc) count <= count - PTR_ONE;
      overflow  <= overflow  | (wr_en & full);
      underflow <= underflow | (rd_en & empty);
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_W - 1)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[PTR_W-2:0]),
    .wdata (data_in),
    .raddr (rd_ptr[PTR_W-2:0]),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      assign data_out = ram_rdata;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk) begin
        if (reset)       dout_q <= '0;
        else if (rd_acc) dout_q <= ram_rdata;
      end
      assign data_out = dout_q;
    end
  endgenerate

  // The pointer distance must always agree with the occupancy register.
  assert property (@(posedge clk) disable iff (reset) count == PTR_W'(wr_ptr - rd_ptr));

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: standard 16x4, FWFT 16x4 and 64x8
// instances share stimulus; the selected one is checked against a queue model.
module tb_sync_fifo_param;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;

  always #5 clk = ~clk;

  logic [3:0] std_dout, fw_dout;
  logic [7:0] big_dout;
  logic [4:0] std_cnt, fw_cnt;
  logic [6:0] big_cnt;
  logic [5:0] std_fl, fw_fl, big_fl;

  sync_fifo_param #(.DATA_WIDTH(4), .DEPTH(16), .FWFT(FWFT_OFF)) u_std (
    .clk(clk), .reset(reset), .data_in(data_in[3:0]), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(std_dout), .full(std_fl[5]), .empty(std_fl[4]), .almost_full(std_fl[3]),
    .almost_empty(std_fl[2]), .count(std_cnt), .overflow(std_fl[1]), .underflow(std_fl[0])
  );

  sync_fifo_param #(.DATA_WIDTH(4), .DEPTH(16), .FWFT(FWFT_ON)) u_fwft (
    .clk(clk), .reset(reset), .data_in(data_in[3:0]), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(fw_dout), .full(fw_fl[5]), .empty(fw_fl[4]), .almost_full(fw_fl[3]),
    .almost_empty(fw_fl[2]), .count(fw_cnt), .overflow(fw_fl[1]), .underflow(fw_fl[0])
  );

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(64), .AFULL_THRESH(60), .AEMPTY_THRESH(4),
                    .FWFT(FWFT_OFF)) u_big (
    .clk(clk), .reset(reset), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(big_dout), .full(big_fl[5]), .empty(big_fl[4]), .almost_full(big_fl[3]),
    .almost_empty(big_fl[2]), .count(big_cnt), .overflow(big_fl[1]), .underflow(big_fl[0])
  );

  int         sel;
  logic [7:0] obs_data;
  logic [6:0] obs_cnt;
  logic [5:0] obs_fl;

  always_comb begin
    obs_data = {4'h0, std_dout};
    obs_cnt  = {2'b00, std_cnt};
    obs_fl   = std_fl;
    if (sel == 1) begin
      obs_data = {4'h0, fw_dout};
      obs_cnt  = {2'b00, fw_cnt};
      obs_fl   = fw_fl;
    end else if (sel == 2) begin
      obs_data = big_dout;
      obs_cnt  = big_cnt;
      obs_fl   = big_fl;
    end
  end

  logic [7:0] mdl_q[$];
  logic [7:0] exp_q[$];
  int         depth, afull_th, aempty_th;
  logic [7:0] mask;
  logic       mdl_ovf, mdl_unf;
  logic       mon_arm;
  int         n_cmp, n_err;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flag vector order: full, empty, almost_full, almost_empty, overflow, underflow.
  task automatic checkState(input string name, input int exp_cnt);
    logic [5:0] exp_fl;
    exp_fl = {exp_cnt == depth, exp_cnt == 0, exp_cnt >= afull_th, exp_cnt <= aempty_th,
              mdl_ovf, mdl_unf};
    checkOutput({name, "/count"}, int'(obs_cnt), exp_cnt);
    checkOutput({name, "/flags"}, int'(obs_fl), int'(exp_fl));
  endtask

  task automatic setConfig(input int s);
    sel = s;
    depth     = (s == 2) ? 64 : 16;
    afull_th  = (s == 2) ? 60 : 14;
    aempty_th = (s == 2) ? 4 : 2;
    mask      = (s == 2) ? 8'hFF : 8'h0F;
  endtask

  task automatic doReset(input logic wr);
    reset   = 1'b1;
    wr_en   = wr;
    rd_en   = 1'b0;
    data_in = 8'h5A;
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    mdl_q.delete();
    exp_q.delete();
    mdl_ovf = 1'b0;
    mdl_unf = 1'b0;
    mon_arm = 1'b0;
  endtask

  // Drives one cycle of inputs and updates the reference queue; for registered
  // read mode the popped word is handed to the monitor for the next edge.
  task automatic applyStimulus(input logic wr, input logic [7:0] din, input logic rd);
    int         cnt;
    logic [7:0] dummy;
    cnt     = mdl_q.size();
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    if (wr && cnt == depth) mdl_ovf = 1'b1;
    if (rd && cnt == 0)     mdl_unf = 1'b1;
    if (rd && cnt != 0) begin
      if (sel == 1) dummy = mdl_q.pop_front();
      else begin
        exp_q.push_back(mdl_q.pop_front());
        mon_arm = 1'b1;
      end
    end
    if (wr && cnt != depth) mdl_q.push_back(din & mask);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_arm) begin
        mon_arm = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("[TB] FAIL rd_data: got 0x%0h, expected nothing queued", obs_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rd_data", int'(obs_data), int'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    n_cmp = 0; n_err = 0; mon_arm = 1'b0; mdl_ovf = 1'b0; mdl_unf = 1'b0;
    setConfig(0);
    @(negedge clk);
    @(negedge clk);
    doReset(1'b0);
    checkState("reset", 0);
    checkOutput("reset_dout", int'(obs_data), 0);

    $display("[TB] standard mode fill/drain");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'((i + 1) % 16), 1'b0);
      checkState($sformatf("fill%0d", i + 1), i + 1);
    end
    applyStimulus(1'b1, 8'h7, 1'b0);
    checkState("overflow_wr", 16);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'h0, 1'b1);
      checkState($sformatf("drain%0d", i), 15 - i);
    end
    applyStimulus(1'b0, 8'h0, 1'b1);
    checkState("underflow_rd", 0);
    checkOutput("hold_dout", int'(obs_data), 0);

    $display("[TB] simultaneous read/write");
    doReset(1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(i + 3), 1'b0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 8'(i * 7 + 1), 1'b1);
      checkState($sformatf("simul%0d", i), 5);
    end
    for (int i = 0; i < 11; i++) applyStimulus(1'b1, 8'(i + 9), 1'b0);
    checkState("refill", 16);
    applyStimulus(1'b1, 8'hE, 1'b1);
    checkState("full_rw", 15);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 8'h0, 1'b1);
    checkState("full_rw_drained", 0);
    doReset(1'b0);
    applyStimulus(1'b1, 8'h9, 1'b1);
    checkState("empty_rw", 1);
    applyStimulus(1'b0, 8'h0, 1'b1);
    checkState("empty_rw_drained", 0);

    $display("[TB] reset mid-stream");
    doReset(1'b0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(i + 1), 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 8'h0, 1'b1);
    checkState("pre_reset", 9);
    doReset(1'b1);
    checkState("mid_reset", 0);
    checkOutput("mid_reset_dout", int'(obs_data), 0);

    $display("[TB] FWFT mode");
    setConfig(1);
    doReset(1'b0);
    checkState("fwft_reset", 0);
    applyStimulus(1'b1, 8'hA, 1'b0);
    checkState("fwft_a", 1);
    checkOutput("fwft_head_a", int'(obs_data), 8'hA);
    applyStimulus(1'b1, 8'hB, 1'b0);
    checkState("fwft_b", 2);
    checkOutput("fwft_head_still_a", int'(obs_data), 8'hA);
    applyStimulus(1'b0, 8'h0, 1'b1);
    checkState("fwft_pop", 1);
    checkOutput("fwft_head_b", int'(obs_data), 8'hB);

    $display("[TB] 64x8 configuration");
    setConfig(2);
    doReset(1'b0);
    checkState("big_reset", 0);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 8'(i * 3 + 1), 1'b0);
      checkState($sformatf("big_fill%0d", i + 1), i + 1);
    end
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b0, 8'h0, 1'b1);
      checkState($sformatf("big_drain%0d", i), 63 - i);
    end
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      checkState("big_rand", mdl_q.size());
    end
    while (mdl_q.size() > 0) applyStimulus(1'b0, 8'h0, 1'b1);
    checkState("big_final", 0);

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL scoreboard_leftover: got %0d, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
